// File: rtl/filter_sequencer_pkg.sv
// Shared types and defaults for the filter sequencer.
// State encoding plus width helper for the timeout counter.
package filter_sequencer_pkg;

  localparam int DEFAULT_DATAWIDTH = 16;
  localparam int DEFAULT_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Bits needed to hold values 0..t without wrapping.
  function automatic int cnt_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/filter_sequencer_sat_counter.sv
// 8-bit saturating up-counter with synchronous clear.
// Used to count samples dropped while the sequencer is busy.
module sat_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins, otherwise increment and stick at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/filter_sequencer.sv
// Sequencer that hands one ADC sample at a time to an external filter.
// Issues once, waits for done or a timeout, and registers the result.
module filter_sequencer
  import filter_sequencer_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic [3:0]           a1_in,
  input  logic [3:0]           a2_in,
  output logic                 once,
  input  logic                 done,
  output logic [DATAWIDTH-1:0] filt_x,
  input  logic [DATAWIDTH-1:0] filt_y,
  output logic [3:0]           a1,
  output logic [3:0]           a2,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 busy,
  output logic [7:0]           overrun_cnt,
  output logic                 timeout_err
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 once_q, once_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_data_q, out_data_d;
  logic [DATAWIDTH-1:0] filt_x_q, filt_x_d;
  logic [3:0]           a1_q, a1_d;
  logic [3:0]           a2_q, a2_d;
  logic                 terr_q, terr_d;

  logic accept;
  logic wait_done;
  logic wait_abort;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign wait_done  = (state_q == S_WAIT) && done;
  assign wait_abort = (state_q == S_WAIT) && !done
                      && (cnt_q == TO_LAST);

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done outside WAIT is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done || (cnt_q == TO_LAST)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; counter saturates at TIMEOUT.
  always_comb begin
    once_d      = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = wait_done;
    out_data_d  = out_data_q;
    filt_x_d    = filt_x_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    terr_d      = terr_q | wait_abort;
    cnt_d       = cnt_q;
    if (accept) begin
      filt_x_d = in_data;
      a1_d     = a1_in;
      a2_d     = a2_in;
    end
    if (wait_done) begin
      out_data_d = filt_y;
    end
    if (state_q == S_START) begin
      cnt_d = '0;
    end else if ((state_q == S_WAIT) && (cnt_q != TO_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      once_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      filt_x_q    <= '0;
      a1_q        <= 4'd0;
      a2_q        <= 4'd0;
      terr_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      once_q      <= once_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      filt_x_q    <= filt_x_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      terr_q      <= terr_d;
    end
  end

  sat_counter u_overrun (
    .clk (clk),
    .clr (rst),
    .inc (in_valid && (state_q != S_IDLE)),
    .cnt (overrun_cnt)
  );

  assign once        = once_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign filt_x      = filt_x_q;
  assign a1          = a1_q;
  assign a2          = a2_q;
  assign timeout_err = terr_q;

endmodule
